// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the execute stage: M-extension opcodes and muldiv FSM states.
package rv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MdMul    = 3'b000,
    MdMulh   = 3'b001,
    MdMulhsu = 3'b010,
    MdMulhu  = 3'b011,
    MdDiv    = 3'b100,
    MdDivu   = 3'b101,
    MdRem    = 3'b110,
    MdRemu   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    MdIdle = 2'b00,
    MdBusyMul = 2'b01,
    MdBusyDiv = 2'b10,
    MdDone = 2'b11
  } md_state_t;

endpackage

// File: rtl/md_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// quot/rem carry the result of the step in progress, so they are final while done is high.
module md_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic            active_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] divisor_q;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;

  always_comb begin
    shifted = {rem_q, quot_q[XLEN-1]};
    diff    = shifted - {1'b0, divisor_q};
    fits    = ~diff[XLEN];
    rem     = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot    = {quot_q[XLEN-2:0], fits};
    done    = active_q && (cnt_q == CntW'(XLEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
    end else if (kill) begin
      active_q <= 1'b0;
    end else if (start) begin
      active_q  <= 1'b1;
      cnt_q     <= '0;
      quot_q    <= dividend;
      rem_q     <= '0;
      divisor_q <= divisor;
    end else if (active_q) begin
      quot_q <= quot;
      rem_q  <= rem;
      cnt_q  <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: pipelined multiply, iterative divide with sign fix-up, and
// single-cycle completion of divide-by-zero / signed-overflow cases.
module muldiv_unit
  import rv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  md_state_t       state_q, state_d;
  md_op_t          op_q, op_d, op;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d;
  logic [2*XLEN-1:0] mul_pipe_q [MUL_LAT];

  logic                     mul_sa, mul_sb, mul_load;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]          mul_res;

  logic            div_signed, a_neg, b_neg, div_zero, div_ovf, div_special, div_start;
  logic [XLEN-1:0] a_mag, b_mag, special_res, div_res, fix_quot, fix_rem;
  logic            div_done;
  logic [XLEN-1:0] div_quot, div_rem;

  always_comb begin
    op       = md_op_t'(funct3_i);
    mul_sa   = (op == MdMulh) || (op == MdMulhsu);
    mul_sb   = (op == MdMulh);
    mul_a    = {mul_sa & op_a_i[XLEN-1], op_a_i};
    mul_b    = {mul_sb & op_b_i[XLEN-1], op_b_i};
    mul_prod = mul_a * mul_b;
    mul_res  = (op_q == MdMul) ? mul_pipe_q[MUL_LAT-1][XLEN-1:0]
                               : mul_pipe_q[MUL_LAT-1][2*XLEN-1:XLEN];
  end

  // Signed ops divide magnitudes; signs are re-applied when the divider finishes.
  always_comb begin
    div_signed  = funct3_i[2] & ~funct3_i[0];
    a_neg       = div_signed & op_a_i[XLEN-1];
    b_neg       = div_signed & op_b_i[XLEN-1];
    a_mag       = a_neg ? -op_a_i : op_a_i;
    b_mag       = b_neg ? -op_b_i : op_b_i;
    div_zero    = (op_b_i == '0);
    div_ovf     = div_signed && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    div_special = div_zero | div_ovf;
    if (funct3_i[1]) special_res = div_zero ? op_a_i : '0;
    else             special_res = div_zero ? '1 : op_a_i;
    fix_quot = quot_neg_q ? -div_quot : div_quot;
    fix_rem  = rem_neg_q ? -div_rem : div_rem;
    div_res  = op_q[1] ? fix_rem : fix_quot;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    mul_load   = 1'b0;
    div_start  = 1'b0;
    if (flush_i) begin
      state_d = MdIdle;
    end else begin
      unique case (state_q)
        MdIdle, MdDone: begin
          if (start_i) begin
            op_d       = op;
            cnt_d      = '0;
            quot_neg_d = a_neg ^ b_neg;
            rem_neg_d  = a_neg;
            if (!funct3_i[2]) begin
              state_d  = MdBusyMul;
              mul_load = 1'b1;
            end else if (div_special) begin
              state_d  = MdDone;
              result_d = special_res;
            end else begin
              state_d   = MdBusyDiv;
              div_start = 1'b1;
            end
          end else begin
            state_d = MdIdle;
          end
        end
        MdBusyMul: begin
          if (cnt_q == 4'(MUL_LAT - 1)) begin
            state_d  = MdDone;
            result_d = mul_res;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MdBusyDiv: begin
          if (div_done) begin
            state_d  = MdDone;
            result_d = div_res;
          end
        end
        default: state_d = MdIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MdIdle;
      op_q       <= MdMul;
      cnt_q      <= '0;
      result_q   <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end

  // Product enters stage 0 at accept and walks one stage per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MUL_LAT); i++) mul_pipe_q[i] <= '0;
    end else begin
      if (mul_load) mul_pipe_q[0] <= mul_prod;
      for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
    end
  end

  md_divider #(
    .XLEN(XLEN)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .kill     (flush_i),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  assign busy_o   = (state_q == MdBusyMul) || (state_q == MdBusyDiv);
  assign valid_o  = (state_q == MdDone);
  assign result_o = result_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(start_i && busy_o))
      else $warning("muldiv_unit: start_i while busy is ignored");
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latencies, special cases, flush, back-to-back, reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start4, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, valid, busy4, valid4;
  logic [31:0] result, result4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_LAT(1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .flush_i  (flush),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result)
  );

  muldiv_unit #(.XLEN(32), .MUL_LAT(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start4),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .flush_i  (flush),
    .busy_o   (busy4),
    .valid_o  (valid4),
    .result_o (result4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; returns just after the accept edge.
  task automatic start_op(input bit use4, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    if (use4) start4 = 1'b1;
    else      start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Latency counts negedges after the accept edge; busy cycles should be latency - 1.
  task automatic wait_check(input string tag, input bit use4, input logic [31:0] exp_res,
                            input int exp_lat, input int lat0);
    int lat   = lat0;
    int nbusy = lat0;
    bit seen  = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (use4 ? valid4 : valid) seen = 1'b1;
      else if (use4 ? busy4 : busy) nbusy++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    check({tag, " result"}, use4 ? result4 : result, exp_res);
  endtask

  task automatic run_op(input string tag, input bit use4, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    @(negedge clk);
    start_op(use4, f3, a, b);
    wait_check(tag, use4, exp_res, exp_lat, 0);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int nv = 0;
    int nb = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid) nv++;
      if (busy) nb++;
    end
    check({tag, " valid count"}, 32'(nv), 32'd0);
    check({tag, " busy count"}, 32'(nb), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start4 = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset result", result, 32'h0);
    check("reset result4", result4, 32'h0);

    // Multiplies
    run_op("mul", 1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    @(negedge clk);
    check("valid single pulse", 32'(valid), 32'd0);
    run_op("mulh", 1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulhsu", 1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("mulhu", 1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulhu lat4", 1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    run_op("mul lat4", 1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);

    // Iterative divides
    run_op("div", 1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem", 1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", 1'b0, 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 1'b0, 3'b111, 32'd100, 32'd7, 32'd2, 33);

    // Single-cycle special cases
    run_op("div ovf", 1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", 1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("rem by zero", 1'b0, 3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op("divu by zero", 1'b0, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

    // Flush 10 cycles into a divide
    @(negedge clk);
    start_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(busy), 32'd0);
    check("flush valid", 32'(valid), 32'd0);
    check("flush result held", result, 32'hFFFF_FFFF);
    quiet_window("after flush", 40);
    run_op("divu after flush", 1'b0, 3'b101, 32'd9, 32'd3, 32'd3, 33);

    // flush and start together: nothing accepted
    @(negedge clk);
    flush = 1'b1;
    start_op(1'b0, 3'b101, 32'd100, 32'd7);
    flush = 1'b0;
    quiet_window("flush+start", 40);
    check("flush+start result held", result, 32'd3);

    // Back-to-back: second start lands in the DONE cycle
    run_op("b2b mul", 1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    start_op(1'b0, 3'b101, 32'd100, 32'd7);
    wait_check("b2b divu", 1'b0, 32'd14, 33, 0);

    // start mid-divide is ignored
    @(negedge clk);
    start_op(1'b0, 3'b111, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start_op(1'b0, 3'b000, 32'd3, 32'd3);
    wait_check("remu ignore mid start", 1'b0, 32'd2, 33, 4);

    // Reset while a multiply is in flight
    @(negedge clk);
    start_op(1'b1, 3'b000, 32'd7, 32'd9);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst mid-mul busy", 32'(busy4), 32'd0);
    check("rst mid-mul valid", 32'(valid4), 32'd0);
    check("rst mid-mul result", result4, 32'h0);
    check("rst main result", result, 32'h0);
    repeat (6) @(negedge clk);
    check("rst mid-mul no late valid", 32'(valid4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
